// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: drives the 2-bit select and enable of a 2-to-4 one-hot decoder.
//   The select index steps from a clock prescaler (auto mode) or from a debounced
//   pushbutton (manual mode). The enable is blanked between selections.
//   Define DECODER_SCAN_GRAY_EN to step the index in Gray order instead of binary.
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset
//   run      - 1 = sequencing, 0 = idle with output blanked
//   mode     - 0 = auto (prescaler), 1 = manual (step_btn)
//   dir      - 0 = ascending index, 1 = descending index
//   step_btn - raw asynchronous pushbutton, active-high
//   sel_en   - registered decoder enable
//   sel      - registered decoder select index
//   wrap     - one-cycle pulse alongside the new sel after a wrapping advance
module decoder_scan_sequencer #(
    parameter int CLK_DIV         = 100000,
    parameter int BLANK_CYCLES    = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       mode,
    input  logic       dir,
    input  logic       step_btn,
    output logic       sel_en,
    output logic [1:0] sel,
    output logic       wrap
);
    localparam int PW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(BLANK_CYCLES + 2);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_BLANK} state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic            db_level_q, db_level_d;
    logic [DW-1:0]   db_cnt_q, db_cnt_d;
    logic            mode_q;
    logic [PW-1:0]   presc_q, presc_d;
    logic [BW-1:0]   blank_q, blank_d;
    logic [1:0]      sel_q, sel_d;
    logic            sel_en_q, sel_en_d;
    logic            wrap_q, wrap_d;
    logic            db_flip, man_evt, auto_evt, step_evt, mode_stable;
    logic [1:0]      cur_bin, nxt_bin, adv_sel;
    logic            adv_wrap;

    // Debounce: the level flips on the edge that completes the required run of mismatches.
    always_comb begin
        db_flip    = (sync2_q != db_level_q) && (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1));
        db_cnt_d   = ((sync2_q != db_level_q) && !db_flip) ? db_cnt_q + 1'b1 : '0;
        db_level_d = db_flip ? ~db_level_q : db_level_q;
        man_evt    = db_flip && !db_level_q;
    end

    // A mode change suppresses events for one cycle so the new source starts cleanly.
    always_comb begin
        mode_stable = (mode == mode_q);
        auto_evt    = (state_q == ST_ACTIVE) && !mode_q && mode_stable &&
                      (presc_q == PW'(CLK_DIV - 1));
        step_evt    = mode_stable && (mode_q ? man_evt : auto_evt);
    end

    // Gray indices are stepped in the binary domain and converted back.
`ifdef DECODER_SCAN_GRAY_EN
    always_comb begin
        cur_bin  = {sel_q[1], sel_q[1] ^ sel_q[0]};
        nxt_bin  = dir ? cur_bin - 2'd1 : cur_bin + 2'd1;
        adv_sel  = nxt_bin ^ {1'b0, nxt_bin[1]};
        adv_wrap = dir ? (cur_bin == 2'd0) : (cur_bin == 2'd3);
    end
`else
    always_comb begin
        cur_bin  = sel_q;
        nxt_bin  = dir ? cur_bin - 2'd1 : cur_bin + 2'd1;
        adv_sel  = nxt_bin;
        adv_wrap = dir ? (cur_bin == 2'd0) : (cur_bin == 2'd3);
    end
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        wrap_d  = 1'b0;
        presc_d = '0;
        blank_d = '0;
        if (!run) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ACTIVE;
                ST_ACTIVE: begin
                    if (!mode && mode_stable)
                        presc_d = auto_evt ? '0 : presc_q + 1'b1;
                    if (step_evt) begin
                        if (BLANK_CYCLES == 0) begin
                            sel_d  = adv_sel;
                            wrap_d = adv_wrap;
                        end else begin
                            state_d = ST_BLANK;
                        end
                    end
                end
                ST_BLANK: begin
                    if (blank_q == BW'(BLANK_CYCLES - 1)) begin
                        sel_d   = adv_sel;
                        wrap_d  = adv_wrap;
                        state_d = ST_ACTIVE;
                    end else begin
                        blank_d = blank_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        sel_en_d = (state_d == ST_ACTIVE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_level_q <= 1'b0;
            db_cnt_q   <= '0;
            mode_q     <= 1'b0;
            presc_q    <= '0;
            blank_q    <= '0;
            sel_q      <= 2'd0;
            sel_en_q   <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= step_btn;
            sync2_q    <= sync1_q;
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            mode_q     <= mode;
            presc_q    <= presc_d;
            blank_q    <= blank_d;
            sel_q      <= sel_d;
            sel_en_q   <= sel_en_d;
            wrap_q     <= wrap_d;
        end
    end

    assign sel_en = sel_en_q;
    assign sel    = sel_q;
    assign wrap   = wrap_q;
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// tb_decoder_scan_sequencer: directed bench for decoder_scan_sequencer
//   with CLK_DIV=4, BLANK_CYCLES=2, DEBOUNCE_CYCLES=3. Inputs are driven and
//   outputs sampled on the falling clock edge.
module tb_decoder_scan_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic       mode = 1'b0;
    logic       dir = 1'b0;
    logic       step_btn = 1'b0;
    logic       sel_en;
    logic [1:0] sel;
    logic       wrap;
    int         checks = 0;
    int         failures = 0;
    logic [1:0] up_seq [5];
    logic [1:0] dn_seq [5];

    decoder_scan_sequencer #(
        .CLK_DIV(4),
        .BLANK_CYCLES(2),
        .DEBOUNCE_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .mode(mode),
        .dir(dir),
        .step_btn(step_btn),
        .sel_en(sel_en),
        .sel(sel),
        .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        run = 1'b0;
        mode = 1'b0;
        dir = 1'b0;
        step_btn = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({wrap, sel_en, sel} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_async got wrap=%b en=%b sel=%0d exp 0/0/0", wrap, sel_en, sel);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({wrap, sel_en, sel} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_idle k=%0d got wrap=%b en=%b sel=%0d exp 0/0/0", k, wrap, sel_en, sel);
            end
        end
    endtask

    task automatic test_auto_up();
        int idx, ph;
        logic [3:0] exp;
        do_reset();
        run = 1'b1;
        checks++;
        if (sel_en !== 1'b0) begin
            failures++;
            $display("FAIL auto_up_pre got en=%b exp 0", sel_en);
        end
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            idx = (k - 1) / 6;
            ph = (k - 1) % 6;
            exp = {(ph == 0 && idx == 4), (ph < 4), up_seq[idx]};
            checks++;
            if ({wrap, sel_en, sel} !== exp) begin
                failures++;
                $display("FAIL auto_up k=%0d got wrap=%b en=%b sel=%0d exp wrap=%b en=%b sel=%0d",
                         k, wrap, sel_en, sel, exp[3], exp[2], exp[1:0]);
            end
        end
    endtask

    task automatic test_auto_down();
        int idx, ph;
        logic [3:0] exp;
        do_reset();
        dir = 1'b1;
        run = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            idx = (k - 1) / 6;
            ph = (k - 1) % 6;
            exp = {(ph == 0 && idx == 1), (ph < 4), dn_seq[idx]};
            checks++;
            if ({wrap, sel_en, sel} !== exp) begin
                failures++;
                $display("FAIL auto_down k=%0d got wrap=%b en=%b sel=%0d exp wrap=%b en=%b sel=%0d",
                         k, wrap, sel_en, sel, exp[3], exp[2], exp[1:0]);
            end
        end
    endtask

    task automatic test_manual();
        logic [3:0] exp;
        do_reset();
        run = 1'b1;
        mode = 1'b1;
        @(negedge clk);
        step_btn = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            exp = {1'b0, !(j == 5 || j == 6), (j >= 7) ? up_seq[1] : 2'd0};
            checks++;
            if ({wrap, sel_en, sel} !== exp) begin
                failures++;
                $display("FAIL manual_step j=%0d got wrap=%b en=%b sel=%0d exp wrap=%b en=%b sel=%0d",
                         j, wrap, sel_en, sel, exp[3], exp[2], exp[1:0]);
            end
            if (j == 10) step_btn = 1'b0;
        end
        repeat (8) @(negedge clk);
        step_btn = 1'b1;
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            if (j == 2) step_btn = 1'b0;
            checks++;
            if ({wrap, sel_en, sel} !== {2'b01, up_seq[1]}) begin
                failures++;
                $display("FAIL manual_glitch j=%0d got wrap=%b en=%b sel=%0d exp wrap=0 en=1 sel=%0d",
                         j, wrap, sel_en, sel, up_seq[1]);
            end
        end
    endtask

    task automatic test_run_abort();
        do_reset();
        run = 1'b1;
        mode = 1'b1;
        @(negedge clk);
        step_btn = 1'b1;
        repeat (8) @(negedge clk);
        step_btn = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if ({sel_en, sel} !== {1'b1, up_seq[1]}) begin
            failures++;
            $display("FAIL abort_setup got en=%b sel=%0d exp en=1 sel=%0d", sel_en, sel, up_seq[1]);
        end
        step_btn = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({sel_en, sel} !== {1'b0, up_seq[1]}) begin
            failures++;
            $display("FAIL abort_in_blank got en=%b sel=%0d exp en=0 sel=%0d", sel_en, sel, up_seq[1]);
        end
        run = 1'b0;
        for (int j = 6; j <= 12; j++) begin
            @(negedge clk);
            if (j == 8) step_btn = 1'b0;
            checks++;
            if ({wrap, sel_en, sel} !== {2'b00, up_seq[1]}) begin
                failures++;
                $display("FAIL abort_idle j=%0d got wrap=%b en=%b sel=%0d exp wrap=0 en=0 sel=%0d",
                         j, wrap, sel_en, sel, up_seq[1]);
            end
        end
        run = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            checks++;
            if ({wrap, sel_en, sel} !== {2'b01, up_seq[1]}) begin
                failures++;
                $display("FAIL abort_resume j=%0d got wrap=%b en=%b sel=%0d exp wrap=0 en=1 sel=%0d",
                         j, wrap, sel_en, sel, up_seq[1]);
            end
        end
    endtask

    task automatic test_async_reset();
        int idx, ph;
        logic [3:0] exp;
        do_reset();
        run = 1'b1;
        repeat (14) @(negedge clk);
        checks++;
        if ({sel_en, sel} !== {1'b1, up_seq[2]}) begin
            failures++;
            $display("FAIL areset_setup got en=%b sel=%0d exp en=1 sel=%0d", sel_en, sel, up_seq[2]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({wrap, sel_en, sel} !== 4'b0000) begin
            failures++;
            $display("FAIL areset_immediate got wrap=%b en=%b sel=%0d exp 0/0/0", wrap, sel_en, sel);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            idx = (k - 1) / 6;
            ph = (k - 1) % 6;
            exp = {1'b0, (ph < 4), up_seq[idx]};
            checks++;
            if ({wrap, sel_en, sel} !== exp) begin
                failures++;
                $display("FAIL areset_restart k=%0d got wrap=%b en=%b sel=%0d exp wrap=%b en=%b sel=%0d",
                         k, wrap, sel_en, sel, exp[3], exp[2], exp[1:0]);
            end
        end
    endtask

    initial begin
`ifdef DECODER_SCAN_GRAY_EN
        up_seq = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd0};
        dn_seq = '{2'd0, 2'd2, 2'd3, 2'd1, 2'd0};
`else
        up_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        dn_seq = '{2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
`endif
        test_reset();
        test_auto_up();
        test_auto_down();
        test_manual();
        test_run_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decoder_scan_sequencer.md
Name: decoder_scan_sequencer

Overview:
- Upstream driver for the 2-to-4 one-hot decoder; produces its 2-bit select and enable.
- Steps the select index automatically from a clock prescaler, or manually from a debounced pushbutton.
- Inserts blanking (enable low) between selections so decoder outputs never glitch across an index change.
- Used for digit/anode scanning and for demo-board stepping of the decoder.

Parameters:
- CLK_DIV, 100000: ACTIVE cycles per index in auto mode; must be ≥ 1.
- BLANK_CYCLES, 2: cycles with sel_en low between indices; 0 means no blanking.
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples needed to accept a new step_btn level; must be ≥ 1.

Ports:
- clk, input, 1: single system clock; all state on its rising edge.
- rst, input, 1: asynchronous active-high reset.
- run, input, 1: 1 = sequencing enabled, 0 = idle with output blanked.
- mode, input, 1: 0 = auto (prescaler), 1 = manual (step_btn).
- dir, input, 1: 0 = ascending index, 1 = descending index.
- step_btn, input, 1: raw asynchronous pushbutton, active-high.
- sel_en, output, 1: enable to the decoder.
- sel, output, 2: select index to the decoder.
- wrap, output, 1: one-cycle pulse when the index wraps.

Behaviour:
- Reset (async, immediate):
  - sel=0, sel_en=0, wrap=0, state=IDLE.
  - Prescaler, blank counter, debounce counter, synchronizer and debounced level all 0.
- step_btn path:
  - 2-flop synchronizer.
  - Debounced level changes only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle restarts the count.
  - A 0→1 change of the debounced level is a one-cycle manual step event.
- Auto step event: prescaler counts only in ACTIVE with mode=0. Event when count==CLK_DIV-1; prescaler then clears. Otherwise the prescaler is held at 0.
- Step event = manual event when mode=1, auto event when mode=0.
- FSM states:
  - IDLE: sel_en=0, sel held. Go to ACTIVE when run=1; sel_en rises the next cycle with sel unchanged.
  - ACTIVE: sel_en=1.
    - Step event with BLANK_CYCLES>0 → BLANK; sel_en falls the next cycle, sel unchanged.
    - Step event with BLANK_CYCLES=0 → sel advances on that edge and the FSM stays in ACTIVE.
  - BLANK: sel_en=0, blank counter counts up.
    - After BLANK_CYCLES cycles: sel advances and sel_en rises on the same edge, and the FSM returns to ACTIVE.
    - Step events arriving in BLANK are dropped.
- run=0 in any state → IDLE on the next edge; sel_en=0 and the index is retained. If this aborts a BLANK, the index does not advance.
- Index advance is modulo 4:
  - dir=0: +1, so 3→0 wraps.
  - dir=1: −1, so 0→3 wraps.
  - dir is sampled on the advance edge.
- wrap is high for exactly the one cycle following a wrapping advance, coincident with the new sel.
- A mode change while ACTIVE clears the prescaler; the new source applies from the next cycle.
- Auto-mode period per index = CLK_DIV + BLANK_CYCLES cycles, with sel_en high for CLK_DIV of them.
- sel and sel_en are registered outputs. sel never changes while sel_en=1, except when BLANK_CYCLES=0.

Optional Feature:
- Macro: DECODER_SCAN_GRAY_EN.
- When defined: the index advances in Gray order.
  - Ascending: 0,1,3,2,0.
  - Descending: 0,2,3,1,0.
  - Adjacent selections differ in one bit.
  - wrap asserts on 2→0 (ascending) and 0→2 (descending).
- When undefined: binary order as described above.
- All timing is identical in both builds.

Test Plan (bench parameters CLK_DIV=4, BLANK_CYCLES=2, DEBOUNCE_CYCLES=3):
- Reset then run=1, mode=0, dir=0:
  - sel_en rises 1 cycle after run, with sel=0.
  - sel_en pattern is 4 high / 2 low.
  - sel sequence is 0,1,2,3,0; wrap pulses once with sel=0 at the 3→0 advance.
- dir=1, auto:
  - from sel=0, next sel=3 with wrap=1, then 2, 1.
- mode=1, step_btn held high 10 cycles:
  - exactly one advance, 0→1, after sync + 3 cycles + 2 blank cycles.
  - a 2-cycle pulse (glitch) produces no advance.
- run dropped in the middle of BLANK (sel=1):
  - sel_en stays 0 and sel stays 1.
  - run=1 again: sel_en rises with sel=1.
- rst asserted mid-ACTIVE at sel=2:
  - sel=0, sel_en=0, wrap=0 immediately, without waiting for a clock edge.
  - the sequence restarts from 0 after run.
- Gray build, auto, dir=0: sel sequence 0,1,3,2,0 with wrap on the 2→0 advance.
